mcl_host_req_credit_ctrl: RTL and testbench

//  Sequences host-to-manycore requests. Packs four 32-bit words drained from the AXI-Lite
//  MM2S FIFO into one 128-bit bsg_mcl_request_s and issues it to the endpoint only while an

---
 rtl/mcl_host_req_credit_ctrl.sv | 120 ++++++++++++
 tb/tb_mcl_host_req_credit_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcl_host_req_credit_ctrl.sv
// mcl_host_req_credit_ctrl: packs four FIFO words (LS word first) into one
// request packet and issues it to the manycore endpoint only while an endpoint
// credit is held. Tracks the available credit count for CSR readback.
//   clk_i / reset_i      clock, synchronous active-high reset
//   word_v_i / word_i    FIFO word in; word_ready_o accepts it
//   flush_i              drop the partial packet (ignored once committed)
//   pkt_v_o / pkt_o      packet out; pkt_ready_i accepts it
//   credit_return_v_i    one endpoint credit returned
//   credits_o            available credits
//   fill_cnt_o           words held in the partial packet
//   credit_ovf_o         sticky: credit returned while already at max
module mcl_host_req_credit_ctrl #(
  parameter int fifo_width_p  = 128,
  parameter int word_width_p  = 32,
  parameter int max_credits_p = 16,
  localparam int credit_width_lp = $clog2(max_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       word_v_i,
  input  logic [word_width_p-1:0]    word_i,
  output logic                       word_ready_o,
  input  logic                       flush_i,
  output logic                       pkt_v_o,
  output logic [fifo_width_p-1:0]    pkt_o,
  input  logic                       pkt_ready_i,
  input  logic                       credit_return_v_i,
  output logic [credit_width_lp-1:0] credits_o,
  output logic [1:0]                 fill_cnt_o,
  output logic                       credit_ovf_o
);

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [credit_width_lp-1:0] max_cred_lp = credit_width_lp'(max_credits_p);
  localparam logic [credit_width_lp-1:0] one_cred_lp = credit_width_lp'(1);

  state_e                     state_q,    state_d;
  logic [1:0]                 fill_cnt_q, fill_cnt_d;
  logic [credit_width_lp-1:0] credits_q,  credits_d;
  logic                       ovf_q,      ovf_d;
  logic [fifo_width_p-1:0]    pkt_q,      pkt_d;

  logic xfer;
  logic send;

  // pkt_v_o comes from registers only; it never looks at pkt_ready_i.
  assign word_ready_o = (state_q == FILL) && !reset_i;
  assign pkt_v_o      = (state_q == ISSUE) && (credits_q != '0);
  assign xfer         = word_v_i && word_ready_o;
  assign send         = pkt_v_o && pkt_ready_i;

  assign pkt_o        = pkt_q;
  assign credits_o    = credits_q;
  assign fill_cnt_o   = fill_cnt_q;
  assign credit_ovf_o = ovf_q;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    pkt_d      = pkt_q;
    unique case (state_q)
      FILL: begin
        // Flush beats a same-cycle word: the word is consumed and dropped.
        if (flush_i) begin
          fill_cnt_d = '0;
        end else if (xfer) begin
          pkt_d[int'(fill_cnt_q)*word_width_p +: word_width_p] = word_i;
          fill_cnt_d = fill_cnt_q + 2'd1;
          if (fill_cnt_q == 2'd3) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (send) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    ovf_d     = ovf_q;
    if (send && !credit_return_v_i) begin
      credits_d = credits_q - one_cred_lp;
    end else if (credit_return_v_i && !send) begin
      if (credits_q == max_cred_lp) begin
        ovf_d = 1'b1;
      end else begin
        credits_d = credits_q + one_cred_lp;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      credits_q  <= max_cred_lp;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      credits_q  <= credits_d;
      ovf_q      <= ovf_d;
    end
  end

  // Packet data needs no reset; it is only meaningful while pkt_v_o is high.
  always_ff @(posedge clk_i) begin
    pkt_q <= pkt_d;
  end

endmodule

// File: tb/tb_mcl_host_req_credit_ctrl.sv
module tb_mcl_host_req_credit_ctrl;

  logic         clk;
  logic         reset_i;
  logic         word_v_i;
  logic [31:0]  word_i;
  logic         word_ready_o;
  logic         flush_i;
  logic         pkt_v_o;
  logic [127:0] pkt_o;
  logic         pkt_ready_i;
  logic         credit_return_v_i;
  logic [4:0]   credits_o;
  logic [1:0]   fill_cnt_o;
  logic         credit_ovf_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  mcl_host_req_credit_ctrl #(
    .fifo_width_p (128),
    .word_width_p (32),
    .max_credits_p(16)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .word_v_i         (word_v_i),
    .word_i           (word_i),
    .word_ready_o     (word_ready_o),
    .flush_i          (flush_i),
    .pkt_v_o          (pkt_v_o),
    .pkt_o            (pkt_o),
    .pkt_ready_i      (pkt_ready_i),
    .credit_return_v_i(credit_return_v_i),
    .credits_o        (credits_o),
    .fill_cnt_o       (fill_cnt_o),
    .credit_ovf_o     (credit_ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         wv;
    logic [31:0]  word;
    logic         flush;
    logic         rdy;
    logic         ret;
    logic         e_wr;
    logic         e_pv;
    logic [1:0]   e_fill;
    logic [4:0]   e_cr;
    logic         e_ovf;
    logic         chk_pkt;
    logic [127:0] e_pkt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are then sampled
  // mid-low-phase, reflecting state after the last rising edge plus the
  // current inputs.
  task automatic drive(input logic rst, input logic wv, input logic [31:0] word,
                       input logic flush, input logic rdy, input logic ret);
    @(negedge clk);
    reset_i           = rst;
    word_v_i          = wv;
    word_i            = word;
    flush_i           = flush;
    pkt_ready_i       = rdy;
    credit_return_v_i = ret;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic load_words(input logic [31:0] base);
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, base + i, 1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic vec_t mk(logic wv, logic [31:0] word, logic flush, logic rdy, logic ret,
                              logic e_wr, logic e_pv, logic [1:0] e_fill, logic [4:0] e_cr,
                              logic chk_pkt, logic [127:0] e_pkt);
    vec_t v;
    v.rst = 1'b0; v.wv = wv; v.word = word; v.flush = flush; v.rdy = rdy; v.ret = ret;
    v.e_wr = e_wr; v.e_pv = e_pv; v.e_fill = e_fill; v.e_cr = e_cr; v.e_ovf = 1'b0;
    v.chk_pkt = chk_pkt; v.e_pkt = e_pkt;
    return v;
  endfunction

  logic [127:0] held_pkt;

  initial begin
    reset_i = 1'b1; word_v_i = 1'b0; word_i = '0; flush_i = 1'b0;
    pkt_ready_i = 1'b0; credit_return_v_i = 1'b0;

    //            wv  word          fl  rdy ret  wr  pv  fill cr  pk  pkt
    vecs.push_back(mk(0, 32'h0,        0, 0, 0,   1, 0, 0, 16, 0, '0));
    vecs.push_back(mk(1, 32'h11111111, 0, 1, 0,   1, 0, 0, 16, 0, '0));
    vecs.push_back(mk(1, 32'h22222222, 0, 1, 0,   1, 0, 1, 16, 0, '0));
    vecs.push_back(mk(1, 32'h33333333, 0, 1, 0,   1, 0, 2, 16, 0, '0));
    vecs.push_back(mk(1, 32'h44444444, 0, 1, 0,   1, 0, 3, 16, 0, '0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0,   0, 1, 0, 16, 1,
                      128'h44444444_33333333_22222222_11111111));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0,   1, 0, 0, 15, 0, '0));
    // two words then flush; next four words form the packet
    vecs.push_back(mk(1, 32'hA0000001, 0, 0, 0,   1, 0, 0, 15, 0, '0));
    vecs.push_back(mk(1, 32'hA0000002, 0, 0, 0,   1, 0, 1, 15, 0, '0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 0,   1, 0, 2, 15, 0, '0));
    vecs.push_back(mk(1, 32'hB0000001, 0, 0, 0,   1, 0, 0, 15, 0, '0));
    vecs.push_back(mk(1, 32'hB0000002, 0, 0, 0,   1, 0, 1, 15, 0, '0));
    vecs.push_back(mk(1, 32'hB0000003, 0, 0, 0,   1, 0, 2, 15, 0, '0));
    vecs.push_back(mk(1, 32'hB0000004, 0, 0, 0,   1, 0, 3, 15, 0, '0));
    // flush in ISSUE is ignored
    vecs.push_back(mk(0, 32'h0,        1, 1, 0,   0, 1, 0, 15, 1,
                      128'hB0000004_B0000003_B0000002_B0000001));
    // flush and word in the same cycle: word dropped
    vecs.push_back(mk(1, 32'hC0000000, 1, 0, 0,   1, 0, 0, 14, 0, '0));
    vecs.push_back(mk(1, 32'hC0000001, 0, 0, 0,   1, 0, 0, 14, 0, '0));
    vecs.push_back(mk(1, 32'hC0000002, 0, 0, 0,   1, 0, 1, 14, 0, '0));
    vecs.push_back(mk(1, 32'hC0000003, 0, 0, 0,   1, 0, 2, 14, 0, '0));
    vecs.push_back(mk(1, 32'hC0000004, 0, 0, 0,   1, 0, 3, 14, 0, '0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0,   0, 1, 0, 14, 1,
                      128'hC0000004_C0000003_C0000002_C0000001));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0,   0, 1, 0, 14, 1,
                      128'hC0000004_C0000003_C0000002_C0000001));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,   1, 0, 0, 13, 0, '0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0,   1, 0, 0, 14, 0, '0));

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_word_ready", word_ready_o, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wv, vecs[i].word, vecs[i].flush, vecs[i].rdy, vecs[i].ret);
      chk($sformatf("v%0d_word_ready", i), word_ready_o, vecs[i].e_wr);
      chk($sformatf("v%0d_pkt_v", i),      pkt_v_o,      vecs[i].e_pv);
      chk($sformatf("v%0d_fill_cnt", i),   fill_cnt_o,   vecs[i].e_fill);
      chk($sformatf("v%0d_credits", i),    credits_o,    vecs[i].e_cr);
      chk($sformatf("v%0d_ovf", i),        credit_ovf_o, vecs[i].e_ovf);
      if (vecs[i].chk_pkt) chk($sformatf("v%0d_pkt", i), pkt_o, vecs[i].e_pkt);
    end

    // Credit exhaustion: 16 sends, then the 17th waits for a return.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int unsigned p = 0; p < 16; p++) begin
      load_words(32'h1000_0000 + (p << 4));
      idle(1'b1);
      chk($sformatf("exh_pkt_v_%0d", p), pkt_v_o, 1);
      chk($sformatf("exh_credits_%0d", p), credits_o, 5'(16 - p));
    end
    idle(1'b0);
    chk("exh_credits_zero", credits_o, 0);
    load_words(32'h2000_0000);
    for (int unsigned c = 0; c < 3; c++) begin
      idle(1'b1);
      chk($sformatf("stall_pkt_v_%0d", c), pkt_v_o, 0);
      chk($sformatf("stall_word_ready_%0d", c), word_ready_o, 0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("ret_cycle_pkt_v", pkt_v_o, 0);
    idle(1'b1);
    chk("after_ret_pkt_v", pkt_v_o, 1);
    chk("after_ret_pkt", pkt_o, 128'h20000003_20000002_20000001_20000000);
    idle(1'b0);
    chk("after_17th_credits", credits_o, 0);
    chk("after_17th_word_ready", word_ready_o, 1);

    // Send and return in the same cycle with one credit.
    load_words(32'h3000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("one_cred_pre_pkt_v", pkt_v_o, 0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("one_cred_pkt_v", pkt_v_o, 1);
    chk("one_cred_credits", credits_o, 1);
    idle(1'b0);
    chk("send_ret_credits", credits_o, 1);
    chk("send_ret_fill_state", word_ready_o, 1);
    chk("send_ret_pkt_v", pkt_v_o, 0);

    // Overflow of the credit counter is sticky until reset.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_pre", credit_ovf_o, 0);
    chk("ovf_pre_credits", credits_o, 16);
    idle(1'b0);
    chk("ovf_set", credit_ovf_o, 1);
    chk("ovf_credits", credits_o, 16);
    load_words(32'h4000_0000);
    idle(1'b1);
    idle(1'b0);
    chk("ovf_sticky", credit_ovf_o, 1);
    chk("ovf_after_send_credits", credits_o, 15);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("ovf_cleared", credit_ovf_o, 0);

    // Reset while a packet is held in ISSUE.
    load_words(32'h6000_0000);
    held_pkt = {32'h60000003, 32'h60000002, 32'h60000001, 32'h60000000};
    for (int unsigned c = 0; c < 10; c++) begin
      if (c == 5) begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("hold_rst_word_ready", word_ready_o, 0);
      end else if (c < 5) begin
        idle(1'b0);
        chk($sformatf("hold_pkt_v_%0d", c), pkt_v_o, 1);
        chk($sformatf("hold_pkt_%0d", c), pkt_o, held_pkt);
        chk($sformatf("hold_word_ready_%0d", c), word_ready_o, 0);
      end else begin
        idle(1'b1);
        chk($sformatf("post_rst_pkt_v_%0d", c), pkt_v_o, 0);
        chk($sformatf("post_rst_credits_%0d", c), credits_o, 16);
      end
    end

    // Reset mid-fill drops the partial words.
    drive(1'b0, 1'b1, 32'h70000001, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h70000002, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h70000003, 1'b0, 1'b0, 1'b0);
    chk("midfill_rst_word_ready", word_ready_o, 0);
    load_words(32'h8000_0000);
    idle(1'b1);
    chk("midfill_pkt_v", pkt_v_o, 1);
    chk("midfill_pkt", pkt_o, 128'h80000003_80000002_80000001_80000000);
    idle(1'b0);
    chk("midfill_credits", credits_o, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
